sio_rx_ctrl: RTL and testbench
==============================

Name: sio_rx_ctrl

Overview:
- Sequences one 4x-oversampled single-bit data recovery unit (DRU) on the remote-IO serial link.
- The DRU captures one NBO-bit word per packet, strobes its valid once, and must be held in reset before the next packet starts.
- This block drives the DRU reset, re-arms it after every word, and checks word parity.
- It buffers the accepted word behind a valid/ready handshake, tracks link-up via a packet timeout, and keeps saturating packet/error/overflow counters.

Parameters:
- NBO, 16, DRU word width. Bit NBO-1 is the even-parity bit over bits NBO-2:0.
- ARM_CYC, 4, cycles the DRU reset is held high on each re-arm. Minimum 1.
- TIMEOUT, 4096, cycles without a good packet before link_up drops. Minimum 2.
- CW, 16, width of the status counters.

Ports:
- c, input, 1, clock (same 400 MHz domain as the DRU).
- r, input, 1, synchronous active-high reset.
- en, input, 1, receiver enable. Low forces the ARM state with dru_r high.
- dru_r, output, 1, reset to the DRU.
- dru_d, input, NBO, DRU output word.
- dru_v, input, 1, DRU word-valid strobe.
- o_d, output, NBO-1, payload: parity bit stripped.
- o_v, output, 1, payload valid.
- o_rdy, input, 1, consumer ready. Transfer occurs on a cycle with o_v and o_rdy both high.
- link_up, output, 1, good packet received within the last TIMEOUT cycles.
- pkt_cnt, output, CW, good packets accepted. Saturating.
- err_cnt, output, CW, parity errors. Saturating.
- ovf_cnt, output, CW, good words dropped because the buffer was full. Saturating.

Behaviour:
- Reset (r=1):
  - State ARM, arm counter 0, dru_r=1.
  - o_v=0, o_d=0, link_up=0, all counters 0, timeout counter 0.
  - r has priority over every other event.
- ARM state:
  - dru_r=1.
  - Arm counter increments each cycle while en=1.
  - When arm counter = ARM_CYC-1, go to LISTEN and clear the counter.
  - en=0 holds the counter at 0.
- LISTEN state:
  - dru_r=0.
  - On dru_v=1, register dru_d and go to CHECK.
  - en=0 returns to ARM immediately.
- CHECK state (1 cycle):
  - dru_r=1. Re-arm starts here, so the DRU is reset one cycle after its strobe.
  - Parity = XOR of the registered word.
  - Parity odd: err_cnt+1, word discarded.
  - Parity even, buffer empty, or a transfer happening this cycle: load o_d, set o_v=1, pkt_cnt+1.
  - Parity even and buffer full with no transfer: ovf_cnt+1, word discarded, pkt_cnt unchanged.
  - Next state ARM, arm counter cleared.
- dru_v in ARM or CHECK is ignored; the DRU is held in reset, so any strobe there is spurious.
- Output buffer:
  - One entry.
  - o_v clears on a transfer unless reloaded in the same cycle.
  - o_d stays stable while o_v=1 and o_rdy=0.
  - Latency from dru_v to o_v is 2 cycles when the buffer is empty.
- Link timeout:
  - Counter clears on every good packet, including overflowed ones (the link is alive).
  - Otherwise it increments, saturating at TIMEOUT.
  - link_up=1 from the cycle after a good packet until the counter reaches TIMEOUT-1, then link_up=0.
  - Parity errors do not refresh the timeout.
- Counters:
  - Saturate at all-ones and never wrap.
  - Events in the same cycle are mutually exclusive by construction.
- Mid-operation changes:
  - en deassertion during CHECK lets CHECK complete, then holds in ARM.
  - en deassertion does not clear the output buffer or the counters.

Decomposition:
- Shared package sio_pkg holds the state encoding (ARM=0, LISTEN=1, CHECK=2) and the saturating-increment helper function.
- Natural sub-module: sio_sat_cnt (parameter CW; inputs c, r, inc; output q), instanced three times.

Test Plan:
- Reset, then en=1, ARM_CYC=4:
  - dru_r high for exactly 4 cycles after reset release, then 0.
  - o_v=0, link_up=0, all counters 0.
- Good word:
  - dru_v with dru_d=16'h0003 (even parity) in LISTEN, o_rdy=1.
  - Required: o_v one cycle at t+2 with o_d=15'h0003; pkt_cnt=1; link_up=1; dru_r high from t+1 for 5 cycles.
- Parity error:
  - dru_d=16'h0001.
  - Required: no o_v, err_cnt=1, pkt_cnt unchanged, link_up unchanged.
- Backpressure:
  - o_rdy=0 and two good words, 16'h0005 then 16'h0006.
  - Required: o_d holds 15'h0005, ovf_cnt=1, pkt_cnt=1.
  - Raise o_rdy: one transfer of 15'h0005, then o_v=0.
- Timeout, with TIMEOUT=16:
  - Good packet, then idle.
  - Required: link_up falls exactly 16 cycles after it rose; a further good packet re-asserts it.
- Spurious strobe, enable and reset:
  - dru_v pulsed during ARM: ignored, no counter change.
  - en=0 in LISTEN: dru_r=1 next cycle.
  - r=1 while o_v=1: o_v=0 next cycle and the counters cleared.

Source files
------------

// File: rtl/sio_pkg.sv
// Shared types and helpers for the remote-IO serial receive controller.
package sio_pkg;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_LISTEN = 2'd1,
        ST_CHECK  = 2'd2
    } sio_state_e;

    // Increment v by one, holding at the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : (v + 64'd1);
    endfunction

endpackage

// File: rtl/sio_rx_ctrl_if.sv
// Payload stream leaving the receive controller: one-entry buffer with valid/ready.
interface sio_rx_ctrl_if #(
    parameter int unsigned NBO = 16
);
    logic [NBO-2:0] o_d;
    logic           o_v;
    logic           o_rdy;

    modport master (output o_d, output o_v, input o_rdy);
    modport slave  (input o_d, input o_v, output o_rdy);
endinterface

// File: rtl/sio_sat_cnt.sv
// Saturating event counter with synchronous active-high reset.
module sio_sat_cnt
    import sio_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          c,
    input  logic          r,
    input  logic          inc,
    output logic [CW-1:0] q
);

    logic [CW-1:0] r_q;

    always_ff @(posedge c) begin
        if (r) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= CW'(sat_inc(64'(r_q), CW));
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sio_rx_ctrl.sv
// Sequences a 4x-oversampled DRU: re-arms it after every word, checks even parity,
// buffers the payload, tracks link-up via a packet timeout and keeps status counters.
module sio_rx_ctrl
    import sio_pkg::*;
#(
    parameter int unsigned NBO     = 16,
    parameter int unsigned ARM_CYC = 4,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CW      = 16
) (
    input  logic              c,
    input  logic              r,
    input  logic              en,
    output logic              dru_r,
    input  logic [NBO-1:0]    dru_d,
    input  logic              dru_v,
    sio_rx_ctrl_if.master     o_if,
    output logic              link_up,
    output logic [CW-1:0]     pkt_cnt,
    output logic [CW-1:0]     err_cnt,
    output logic [CW-1:0]     ovf_cnt
);

    localparam int unsigned AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    sio_state_e     r_state, w_state;
    logic [AW-1:0]  r_arm_cnt, w_arm_cnt;
    logic [NBO-1:0] r_word, w_word;
    logic [NBO-2:0] r_od, w_od;
    logic           r_ov, w_ov;
    logic           r_dru_r, w_dru_r;
    logic [TW-1:0]  r_tcnt, w_tcnt;
    logic           r_link, w_link;
    logic           w_xfer, w_good, w_load;
    logic           w_pkt_inc, w_err_inc, w_ovf_inc;

    // State, buffer and timeout registers.
    always_ff @(posedge c) begin
        if (r) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            r_word    <= '0;
            r_od      <= '0;
            r_ov      <= 1'b0;
            r_dru_r   <= 1'b1;
            r_tcnt    <= '0;
            r_link    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_arm_cnt <= w_arm_cnt;
            r_word    <= w_word;
            r_od      <= w_od;
            r_ov      <= w_ov;
            r_dru_r   <= w_dru_r;
            r_tcnt    <= w_tcnt;
            r_link    <= w_link;
        end
    end

    // Next-state, buffer and event decode.
    always_comb begin
        w_state   = r_state;
        w_arm_cnt = r_arm_cnt;
        w_word    = r_word;
        w_od      = r_od;
        w_ov      = r_ov;
        w_good    = 1'b0;
        w_load    = 1'b0;
        w_pkt_inc = 1'b0;
        w_err_inc = 1'b0;
        w_ovf_inc = 1'b0;
        w_xfer    = r_ov & o_if.o_rdy;

        case (r_state)
            ST_ARM: begin
                if (!en) begin
                    w_arm_cnt = '0;
                end else if (r_arm_cnt == ARM_LAST) begin
                    w_state   = ST_LISTEN;
                    w_arm_cnt = '0;
                end else begin
                    w_arm_cnt = r_arm_cnt + AW'(1);
                end
            end
            ST_LISTEN: begin
                if (!en) begin
                    w_state = ST_ARM;
                end else if (dru_v) begin
                    w_word  = dru_d;
                    w_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state   = ST_ARM;
                w_arm_cnt = '0;
                if (^r_word) begin
                    w_err_inc = 1'b1;
                end else begin
                    w_good = 1'b1;
                    if (!r_ov || w_xfer) begin
                        w_load    = 1'b1;
                        w_pkt_inc = 1'b1;
                    end else begin
                        w_ovf_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state   = ST_ARM;
                w_arm_cnt = '0;
            end
        endcase

        // DRU reset leads the state so it is released exactly when listening starts.
        w_dru_r = (w_state != ST_LISTEN);

        if (w_load) begin
            w_od = r_word[NBO-2:0];
            w_ov = 1'b1;
        end else if (w_xfer) begin
            w_ov = 1'b0;
        end

        if (w_good) begin
            w_tcnt = '0;
        end else if (r_tcnt < T_MAX) begin
            w_tcnt = r_tcnt + TW'(1);
        end else begin
            w_tcnt = r_tcnt;
        end

        w_link = w_good | (r_link & (r_tcnt < T_LAST));
    end

    sio_sat_cnt #(.CW(CW)) u_pkt_cnt (.c(c), .r(r), .inc(w_pkt_inc), .q(pkt_cnt));
    sio_sat_cnt #(.CW(CW)) u_err_cnt (.c(c), .r(r), .inc(w_err_inc), .q(err_cnt));
    sio_sat_cnt #(.CW(CW)) u_ovf_cnt (.c(c), .r(r), .inc(w_ovf_inc), .q(ovf_cnt));

    assign dru_r     = r_dru_r;
    assign link_up   = r_link;
    assign o_if.o_d  = r_od;
    assign o_if.o_v  = r_ov;

endmodule

// File: tb/tb_sio_rx_ctrl.sv
// Bench for sio_rx_ctrl: directed scenarios with literal checks plus a randomized run,
// all outputs compared every cycle against a timestamp/countdown model of the receiver.
module tb_sio_rx_ctrl;

    localparam int unsigned NBO     = 16;
    localparam int unsigned ARM_CYC = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CW      = 4;
    localparam int          CMAX    = (1 << CW) - 1;

    logic           c;
    logic           r;
    logic           en;
    logic           dru_r;
    logic [NBO-1:0] dru_d;
    logic           dru_v;
    logic           link_up;
    logic [CW-1:0]  pkt_cnt, err_cnt, ovf_cnt;

    sio_rx_ctrl_if #(.NBO(NBO)) u_if ();

    sio_rx_ctrl #(
        .NBO(NBO), .ARM_CYC(ARM_CYC), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .c(c), .r(r), .en(en), .dru_r(dru_r), .dru_d(dru_d), .dru_v(dru_v),
        .o_if(u_if), .link_up(link_up),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: countdown of enabled arm cycles, a pending word awaiting
    // its check, a one-deep buffer, and a timestamp of the last good packet.
    bit             m_valid = 1'b0;
    int             m_cyc = 0;
    int             m_arm_left = 0;
    bit             m_have = 1'b0;
    logic [NBO-1:0] m_word = '0;
    bit             m_ov = 1'b0;
    logic [NBO-2:0] m_od = '0;
    int             m_pkt = 0, m_err = 0, m_ovf = 0;
    int             m_last_good = -1;
    bit             m_xfer, m_loaded;

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    always @(posedge c) begin
        m_cyc++;
        if (r) begin
            m_valid = 1'b1;
            m_arm_left = ARM_CYC;
            m_have = 1'b0;
            m_ov = 1'b0;
            m_od = '0;
            m_pkt = 0; m_err = 0; m_ovf = 0;
            m_last_good = -1;
        end else if (m_valid) begin
            m_xfer = m_ov && u_if.o_rdy;
            m_loaded = 1'b0;
            if (m_have) begin
                m_have = 1'b0;
                m_arm_left = ARM_CYC;
                if (($countones(m_word) % 2) != 0) begin
                    m_err = sat(m_err);
                end else begin
                    m_last_good = m_cyc;
                    if (!m_ov || m_xfer) begin
                        m_ov = 1'b1;
                        m_od = m_word[NBO-2:0];
                        m_pkt = sat(m_pkt);
                        m_loaded = 1'b1;
                    end else begin
                        m_ovf = sat(m_ovf);
                    end
                end
            end else if (m_arm_left > 0) begin
                m_arm_left = en ? m_arm_left - 1 : ARM_CYC;
            end else if (!en) begin
                m_arm_left = ARM_CYC;
            end else if (dru_v) begin
                m_have = 1'b1;
                m_word = dru_d;
            end
            if (m_xfer && !m_loaded) m_ov = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge c) begin
        if (m_valid) begin
            chk("dru_r",   32'(dru_r),     32'(m_have || (m_arm_left > 0)));
            chk("o_v",     32'(u_if.o_v),  32'(m_ov));
            chk("o_d",     32'(u_if.o_d),  32'(m_od));
            chk("link_up", 32'(link_up),
                32'((m_last_good >= 0) && ((m_cyc - m_last_good) < int'(TIMEOUT))));
            chk("pkt_cnt", 32'(pkt_cnt),   32'(m_pkt));
            chk("err_cnt", 32'(err_cnt),   32'(m_err));
            chk("ovf_cnt", 32'(ovf_cnt),   32'(m_ovf));
        end
    end

    task automatic step();
        @(negedge c);
        #1;
    endtask

    task automatic wait_listen();
        int k = 0;
        while (dru_r !== 1'b0 && k < 50) begin
            step();
            k++;
        end
        chk("listen_reached", 32'(dru_r), 32'd0);
    endtask

    task automatic pulse(input logic [NBO-1:0] w);
        dru_v = 1'b1;
        dru_d = w;
        step();
        dru_v = 1'b0;
    endtask

    int n;

    initial begin
        r = 1'b1; en = 1'b1; dru_v = 1'b0; dru_d = '0; u_if.o_rdy = 1'b1;
        step(); step();
        chk("rst_dru_r", 32'(dru_r), 32'd1);
        chk("rst_o_v", 32'(u_if.o_v), 32'd0);
        chk("rst_link", 32'(link_up), 32'd0);
        chk("rst_cnts", 32'({pkt_cnt, err_cnt, ovf_cnt}), 32'd0);

        // Arm period after reset release.
        r = 1'b0;
        n = 0;
        while (dru_r === 1'b1 && n < 20) begin n++; step(); end
        chk("arm_cycles", 32'(n), 32'd4);

        // Good word with ready consumer.
        wait_listen();
        pulse(16'h0003);
        chk("chk_dru_r", 32'(dru_r), 32'd1);
        chk("chk_o_v", 32'(u_if.o_v), 32'd0);
        step();
        chk("good_o_v", 32'(u_if.o_v), 32'd1);
        chk("good_o_d", 32'(u_if.o_d), 32'h0003);
        chk("good_pkt", 32'(pkt_cnt), 32'd1);
        chk("good_link", 32'(link_up), 32'd1);
        n = 1;
        while (dru_r === 1'b1 && n < 20) begin n++; step(); end
        chk("rearm_cycles", 32'(n), 32'd5);

        // Parity error.
        wait_listen();
        pulse(16'h0001);
        step(); step();
        chk("perr_err", 32'(err_cnt), 32'd1);
        chk("perr_pkt", 32'(pkt_cnt), 32'd1);
        chk("perr_link", 32'(link_up), 32'd1);

        // Backpressure: second word overflows.
        u_if.o_rdy = 1'b0;
        wait_listen();
        pulse(16'h0005);
        step();
        wait_listen();
        pulse(16'h0006);
        step(); step();
        chk("bp_o_v", 32'(u_if.o_v), 32'd1);
        chk("bp_o_d", 32'(u_if.o_d), 32'h0005);
        chk("bp_ovf", 32'(ovf_cnt), 32'd1);
        chk("bp_pkt", 32'(pkt_cnt), 32'd2);
        u_if.o_rdy = 1'b1;
        step();
        chk("bp_drain", 32'(u_if.o_v), 32'd0);

        // Link timeout.
        n = 0;
        while (link_up !== 1'b0 && n < 100) begin n++; step(); end
        chk("link_dropped", 32'(link_up), 32'd0);
        wait_listen();
        pulse(16'h8001);
        step();
        chk("to_rise", 32'(link_up), 32'd1);
        chk("to_o_d", 32'(u_if.o_d), 32'h0001);
        n = 0;
        while (link_up === 1'b1 && n < 100) begin n++; step(); end
        chk("to_high_cycles", 32'(n), 32'd16);
        wait_listen();
        pulse(16'h0003);
        step();
        chk("to_reassert", 32'(link_up), 32'd1);

        // Spurious strobes while armed.
        dru_v = 1'b1;
        dru_d = 16'h0003;
        step(); step();
        dru_v = 1'b0;
        wait_listen();
        step(); step();
        chk("spur_pkt", 32'(pkt_cnt), 32'd4);
        chk("spur_err", 32'(err_cnt), 32'd1);

        // Enable drop while listening.
        wait_listen();
        en = 1'b0;
        step();
        chk("en_off_dru_r", 32'(dru_r), 32'd1);
        step(); step();
        chk("en_off_hold", 32'(dru_r), 32'd1);
        en = 1'b1;

        // Enable drop during the check, then reset with a full buffer.
        u_if.o_rdy = 1'b0;
        wait_listen();
        pulse(16'h0003);
        en = 1'b0;
        step();
        chk("en_chk_o_v", 32'(u_if.o_v), 32'd1);
        chk("en_chk_pkt", 32'(pkt_cnt), 32'd5);
        step(); step();
        chk("en_chk_hold", 32'(dru_r), 32'd1);
        r = 1'b1;
        step();
        chk("rst_mid_o_v", 32'(u_if.o_v), 32'd0);
        chk("rst_mid_cnts", 32'({pkt_cnt, err_cnt, ovf_cnt}), 32'd0);
        r = 1'b0; en = 1'b1; u_if.o_rdy = 1'b1;

        // Error counter saturation.
        for (int i = 0; i < 17; i++) begin
            wait_listen();
            pulse(16'h0001);
        end
        step(); step();
        chk("err_sat", 32'(err_cnt), 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 19) != 0);
            dru_v = ($urandom_range(0, 3) == 0);
            dru_d = 16'($urandom);
            u_if.o_rdy = 1'($urandom_range(0, 1));
            step();
        end
        r = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
